sseg_scan: RTL and testbench

SSEG_SCAN -- requirements
Module: sseg_scan

---
 rtl/sseg_pkg.sv | 24 ++
 rtl/sseg_if.sv | 15 +
 rtl/hex2seg.sv | 11 +
 rtl/sseg_scan.sv | 177 +++++++++++++++++
 tb/tb_sseg_scan.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scanner: segment bit order,
// the hex glyph table and the number of brightness steps per slot.
package sseg_pkg;

  localparam int SEG_W = 7;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam int BRIGHT_STEPS = 16;

  typedef logic [SEG_W-1:0] seg_t;

  // Entry n is the active-high glyph for hex digit n (bit0=a .. bit6=g).
  localparam seg_t HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/sseg_if.sv
// Load channel of the scanner: new digit/decimal-point values offered with
// load, accepted while ready is high.
interface sseg_if #(
  parameter int NDIG = 8
) ();

  logic [4*NDIG-1:0] data_in;
  logic [NDIG-1:0]   dp_in;
  logic              load;
  logic              ready;

  modport master (output data_in, output dp_in, output load, input ready);
  modport slave  (input data_in, input dp_in, input load, output ready);

endinterface

// File: rtl/hex2seg.sv
// Combinational hex nibble to active-high seven-segment glyph.
module hex2seg
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       pattern
);

  assign pattern = HEX_SEG[nibble];

endmodule

// File: rtl/sseg_scan.sv
// Multiplexed seven-segment scanner with double-buffered digit data,
// leading-zero suppression, PWM brightness and per-digit blinking.
module sseg_scan
  import sseg_pkg::*;
#(
  parameter int NDIG         = 8,
  parameter int DIV          = 200000,
  parameter int BLINK_FRAMES = 64,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  sseg_if.slave            bus,
  input  logic             lz_blank,
  input  logic [NDIG-1:0]  blink_mask,
  input  logic [3:0]       brightness,
  output logic [NDIG-1:0]  an,
  output seg_t             seg,
  output logic             dp,
  output logic             frame
);

  localparam int CW   = $clog2(DIV);
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int STEP = DIV / BRIGHT_STEPS;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0]     cnt_reg;
  logic [IW-1:0]     idx_reg;
  logic [FW-1:0]     frm_reg;
  logic              phase_reg;
  logic [4*NDIG-1:0] active_data_reg;
  logic [NDIG-1:0]   active_dp_reg;
  logic [4*NDIG-1:0] pend_data_reg;
  logic [NDIG-1:0]   pend_dp_reg;
  logic              pend_full_reg;
  logic [NDIG-1:0]   an_reg;
  seg_t              seg_reg;
  logic              dp_reg;

  logic              slot_end;
  logic              boundary;
  logic [NDIG-1:0]   nz_above;
  logic [NDIG-1:0]   lz_hide;
  logic [CW:0]       on_limit;
  logic              digit_on;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_hide;
  logic              cur_blink;
  logic              blank;
  seg_t              cur_pat;
  logic [NDIG-1:0]   an_next;
  seg_t              seg_next;
  logic              dp_next;

  assign slot_end  = (cnt_reg == CNT_LAST);
  assign boundary  = slot_end && (idx_reg == IDX_LAST);
  assign frame     = boundary;
  assign bus.ready = !pend_full_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else if (slot_end) begin
      cnt_reg <= '0;
      idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Transfer and accept are exclusive: a load can only be taken while pending
  // is empty, so a load in the boundary cycle waits for the next boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_data_reg <= '0;
      active_dp_reg   <= '0;
      pend_data_reg   <= '0;
      pend_dp_reg     <= '0;
      pend_full_reg   <= 1'b0;
    end else begin
      if (boundary && pend_full_reg) begin
        active_data_reg <= pend_data_reg;
        active_dp_reg   <= pend_dp_reg;
        pend_full_reg   <= 1'b0;
      end
      if (bus.load && !pend_full_reg) begin
        pend_data_reg <= bus.data_in;
        pend_dp_reg   <= bus.dp_in;
        pend_full_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_reg   <= '0;
      phase_reg <= 1'b1;
    end else if (boundary) begin
      if (frm_reg == FRM_LAST) begin
        frm_reg   <= '0;
        phase_reg <= !phase_reg;
      end else begin
        frm_reg <= frm_reg + 1'b1;
      end
    end
  end

  // nz_above[i]: some digit strictly above i is nonzero in the active buffer.
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_lz
      if (gi == NDIG - 1) begin : g_top
        assign nz_above[gi] = 1'b0;
      end else begin : g_mid
        assign nz_above[gi] = nz_above[gi+1] | (|active_data_reg[4*(gi+1) +: 4]);
      end
      if (gi == 0) begin : g_d0
        assign lz_hide[gi] = 1'b0;
      end else begin : g_dn
        assign lz_hide[gi] = lz_blank && !nz_above[gi] && (active_data_reg[4*gi +: 4] == 4'h0);
      end
    end
  endgenerate

  // Full level is forced on so DIV values that are not a multiple of 16 still light the whole slot.
  assign on_limit = (CW+1)'((int'(brightness) + 1) * STEP);
  assign digit_on = (brightness == 4'hF) || ({1'b0, cnt_reg} < on_limit);

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_hide  = 1'b0;
    cur_blink = 1'b0;
    an_next   = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_reg == IW'(i)) begin
        cur_nib    = active_data_reg[4*i +: 4];
        cur_dp     = active_dp_reg[i];
        cur_hide   = lz_hide[i];
        cur_blink  = blink_mask[i];
        an_next[i] = digit_on;
      end
    end
  end

  hex2seg u_hex2seg (
    .nibble  (cur_nib),
    .pattern (cur_pat)
  );

  assign blank    = cur_hide || (!phase_reg && cur_blink);
  assign seg_next = (digit_on && !blank) ? cur_pat : '0;
  assign dp_next  = digit_on && !blank && cur_dp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_reg  <= {NDIG{ACTIVE_LOW}};
      seg_reg <= {SEG_W{ACTIVE_LOW}};
      dp_reg  <= ACTIVE_LOW;
    end else begin
      an_reg  <= an_next ^ {NDIG{ACTIVE_LOW}};
      seg_reg <= seg_next ^ {SEG_W{ACTIVE_LOW}};
      dp_reg  <= dp_next ^ ACTIVE_LOW;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = dp_reg;

endmodule

// File: tb/tb_sseg_scan.sv
// Scoreboard bench for sseg_scan (NDIG=4, DIV=16, BLINK_FRAMES=2, active low).
module tb_sseg_scan;

  localparam int NDIG  = 4;
  localparam int DIV   = 16;
  localparam int BLINK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lz_blank;
  logic [3:0] blink_mask;
  logic [3:0] brightness;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame;

  always #5 clk = ~clk;

  sseg_if #(.NDIG(NDIG)) bus ();

  sseg_scan #(
    .NDIG         (NDIG),
    .DIV          (DIV),
    .BLINK_FRAMES (BLINK),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .lz_blank   (lz_blank),
    .blink_mask (blink_mask),
    .brightness (brightness),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame      (frame)
  );

  // Active-high glyphs, a = bit0.
  logic [6:0] hexp [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef enum {K_DISP, K_READY, K_FRAME} kind_t;
  typedef struct {
    int         t;
    string      name;
    kind_t      kind;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       chk_seg;
    logic       bitv;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tcyc  = 0;
  int   base_r = 0;

  always @(posedge clk) tcyc <= tcyc + 1;

  function automatic exp_t mk(int t, string name, kind_t k, logic [3:0] an_v,
                              logic [6:0] seg_v, logic dp_v, logic chk, logic b);
    exp_t e;
    e.t = t; e.name = name; e.kind = k; e.an = an_v; e.seg = seg_v;
    e.dp = dp_v; e.chk_seg = chk; e.bitv = b;
    return e;
  endfunction

  task automatic push(input exp_t e);
    int i;
    i = sb.size();
    while (i > 0 && sb[i-1].t > e.t) i--;
    sb.insert(i, e);
  endtask

  // State p (p edges after reset release) is visible on ready/frame at tcyc R+p
  // and on the registered an/seg/dp one cycle later.
  task automatic exp_lit(string name, int p, int d, int nib, logic dpv);
    push(mk(base_r + p + 1, name, K_DISP, ~(4'b0001 << d), ~hexp[nib[3:0]], ~dpv, 1'b1, 1'b0));
  endtask

  task automatic exp_blank(string name, int p, int d);
    push(mk(base_r + p + 1, name, K_DISP, ~(4'b0001 << d), 7'h7F, 1'b1, 1'b1, 1'b0));
  endtask

  task automatic exp_dark(string name, int p);
    push(mk(base_r + p + 1, name, K_DISP, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic exp_rdy(string name, int p, logic v);
    push(mk(base_r + p, name, K_READY, 4'h0, 7'h00, 1'b0, 1'b0, v));
  endtask

  task automatic exp_frm(string name, int p, logic v);
    push(mk(base_r + p, name, K_FRAME, 4'h0, 7'h00, 1'b0, 1'b0, v));
  endtask

  task automatic at_state(int p);
    while (tcyc < base_r + p) @(negedge clk);
  endtask

  task automatic check(input exp_t e);
    logic ok;
    n_cmp++;
    case (e.kind)
      K_DISP:  ok = (an === e.an) && (!e.chk_seg || (seg === e.seg && dp === e.dp));
      K_READY: ok = (bus.ready === e.bitv);
      default: ok = (frame === e.bitv);
    endcase
    if (e.t != tcyc) ok = 1'b0;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s t=%0d now=%0d: got an=%b seg=%b dp=%b ready=%b frame=%b; want an=%b seg=%b dp=%b flag=%b",
               e.name, e.t, tcyc, an, seg, dp, bus.ready, frame, e.an, e.seg, e.dp, e.bitv);
    end else begin
      $display("check %s t=%0d ok", e.name, e.t);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].t <= tcyc) begin
      cur = sb.pop_front();
      check(cur);
    end
  end

  initial begin
    int n_12af [4] = '{15, 10, 2, 1};
    int n_3456 [4] = '{6, 5, 4, 3};
    int n_0789 [4] = '{9, 8, 7, 0};
    int guard;

    bus.data_in = '0; bus.dp_in = '0; bus.load = 1'b0;
    lz_blank = 1'b0; blink_mask = 4'h0; brightness = 4'hF;

    repeat (3) @(negedge clk);
    push(mk(tcyc + 1, "rst_outputs", K_DISP, 4'hF, 7'h7F, 1'b1, 1'b1, 1'b0));
    push(mk(tcyc + 1, "rst_ready", K_READY, 4'h0, 7'h00, 1'b0, 1'b0, 1'b1));
    push(mk(tcyc + 1, "rst_frame", K_FRAME, 4'h0, 7'h00, 1'b0, 1'b0, 1'b0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base_r = tcyc;

    // Plain scan of an all-zero buffer and frame pulses.
    for (int d = 0; d < 4; d++) begin
      exp_lit("scan_c0", 16*d, d, 0, 1'b0);
      exp_lit("scan_c15", 16*d + 15, d, 0, 1'b0);
    end
    exp_rdy("idle_ready", 10, 1'b1);
    exp_frm("frame_62", 62, 1'b0);
    exp_frm("frame_63", 63, 1'b1);
    exp_frm("frame_64", 64, 1'b0);
    exp_frm("frame_127", 127, 1'b1);

    // Mid-frame load of 0x12AF with dp on digit 2.
    exp_rdy("pre_load_ready", 84, 1'b1);
    exp_rdy("load_ready_low", 85, 1'b0);
    exp_lit("midframe_hold", 117, 3, 0, 1'b0);
    exp_rdy("ready_hold", 127, 1'b0);
    exp_rdy("ready_return", 128, 1'b1);
    for (int d = 0; d < 4; d++) exp_lit("new_frame_12af", 128 + 16*d + 2, d, n_12af[d], d == 2);
    at_state(84);
    bus.data_in = 16'h12AF; bus.dp_in = 4'b0100; bus.load = 1'b1;
    at_state(85);
    bus.load = 1'b0;

    // Load while busy is ignored; load in the boundary cycle waits a frame.
    exp_rdy("accept_3456", 141, 1'b0);
    exp_rdy("ignored_keeps_low", 152, 1'b0);
    exp_rdy("ready_192", 192, 1'b1);
    for (int d = 0; d < 4; d++) exp_lit("ignored_load", 192 + 16*d + 2, d, n_3456[d], 1'b0);
    exp_rdy("boundary_load", 256, 1'b0);
    exp_lit("boundary_wait_d0", 256 + 1, 0, 6, 1'b0);
    exp_lit("boundary_wait_d3", 256 + 48 + 1, 3, 3, 1'b0);
    exp_rdy("boundary_xfer", 320, 1'b1);
    for (int d = 0; d < 4; d++) exp_lit("boundary_shown", 320 + 16*d + 2, d, n_0789[d], d == 0);
    at_state(140);
    bus.data_in = 16'h3456; bus.dp_in = 4'b0000; bus.load = 1'b1;
    at_state(141);
    bus.load = 1'b0;
    at_state(150);
    bus.data_in = 16'hFFFF; bus.dp_in = 4'b1111; bus.load = 1'b1;
    at_state(151);
    bus.load = 1'b0;
    at_state(255);
    bus.data_in = 16'h0789; bus.dp_in = 4'b0001; bus.load = 1'b1;
    at_state(256);
    bus.load = 1'b0;

    // Leading-zero suppression.
    exp_rdy("lz_accept", 331, 1'b0);
    exp_blank("lz_d3", 384 + 48 + 2, 3);
    exp_blank("lz_d2", 384 + 32 + 2, 2);
    exp_lit("lz_d1", 384 + 16 + 2, 1, 5, 1'b0);
    exp_lit("lz_d0", 384 + 2, 0, 0, 1'b0);
    exp_rdy("zero_accept", 401, 1'b0);
    for (int d = 1; d < 4; d++) exp_blank("lz_zero_hi", 448 + 16*d + 2, d);
    exp_lit("lz_zero_d0", 448 + 2, 0, 0, 1'b0);
    at_state(330);
    bus.data_in = 16'h0050; bus.dp_in = 4'b1000; bus.load = 1'b1;
    at_state(331);
    bus.load = 1'b0;
    at_state(383);
    lz_blank = 1'b1;
    at_state(400);
    bus.data_in = 16'h0000; bus.dp_in = 4'b0000; bus.load = 1'b1;
    at_state(401);
    bus.load = 1'b0;

    // Brightness.
    exp_lit("bright3_on", 512 + 3, 0, 0, 1'b0);
    exp_dark("bright3_off", 512 + 4);
    exp_dark("bright3_end", 512 + 15);
    exp_lit("bright3_d2", 512 + 32, 2, 0, 1'b0);
    exp_lit("bright3_d3", 512 + 48 + 3, 3, 0, 1'b0);
    exp_dark("bright3_d3off", 512 + 48 + 4);
    exp_lit("bright15_d0", 576 + 15, 0, 0, 1'b0);
    exp_lit("bright15_d1", 576 + 31, 1, 0, 1'b0);
    at_state(511);
    brightness = 4'd3; lz_blank = 1'b0;
    at_state(575);
    brightness = 4'hF;

    // Blink on digit 0: phase off in frames where (frame/2) is odd.
    exp_blank("blink_f10_d0", 640 + 2, 0);
    exp_lit("blink_f10_d1", 640 + 16 + 2, 1, 0, 1'b0);
    exp_blank("blink_f11_d0", 704 + 2, 0);
    exp_lit("blink_f12_d0", 768 + 2, 0, 0, 1'b0);
    exp_lit("blink_f13_d0", 832 + 2, 0, 0, 1'b0);
    exp_blank("blink_f14_d0", 896 + 2, 0);
    exp_lit("blink_f14_d3", 896 + 48 + 2, 3, 0, 1'b0);
    at_state(639);
    blink_mask = 4'b0001;
    at_state(959);
    blink_mask = 4'b0000;

    // Reset mid-slot with pending full.
    exp_rdy("abcd_accept", 966, 1'b0);
    at_state(965);
    bus.data_in = 16'hABCD; bus.dp_in = 4'b1111; bus.load = 1'b1;
    at_state(966);
    bus.load = 1'b0;
    at_state(970);
    @(posedge clk);
    #1 rst = 1'b1;
    push(mk(tcyc, "async_rst_out", K_DISP, 4'hF, 7'h7F, 1'b1, 1'b1, 1'b0));
    push(mk(tcyc, "async_rst_ready", K_READY, 4'h0, 7'h00, 1'b0, 1'b0, 1'b1));
    push(mk(tcyc, "async_rst_frame", K_FRAME, 4'h0, 7'h00, 1'b0, 1'b0, 1'b0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base_r = tcyc;
    exp_lit("post_rst_d0", 2, 0, 0, 1'b0);
    exp_rdy("post_rst_ready", 5, 1'b1);
    exp_frm("post_rst_frame", 63, 1'b1);
    exp_lit("post_rst_f1_d0", 64 + 2, 0, 0, 1'b0);
    exp_rdy("post_rst_ready2", 70, 1'b1);
    exp_lit("post_rst_f1_d3", 64 + 48 + 2, 3, 0, 1'b0);
    at_state(130);

    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s t=%0d: never compared, expected flag=%b an=%b", cur.name, cur.t, cur.bitv, cur.an);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
